// File: rtl/actbuf_pingpong_ctrl.sv
// rtl/actbuf_pingpong_ctrl.sv - ping-pong activation buffer bank sequencer
// Grants the two banks alternately to the DMA writer and the PE so fill overlaps compute.
module actbuf_pingpong_ctrl #(
  parameter int AWIDTH = 9,
  parameter int DEPTH  = 264
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              wr_req,
  output logic              wr_ack,
  output logic              wr_bank,
  input  logic              wr_done,
  input  logic [AWIDTH-1:0] wr_count,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic              rd_bank,
  output logic [AWIDTH-1:0] rd_count,
  input  logic              rd_done,
  output logic [1:0]        bank_full,
  output logic              proto_err
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bankState_t;

  localparam logic [AWIDTH-1:0] DepthW = AWIDTH'(DEPTH);

  bankState_t        bankState     [2];
  bankState_t        bankStateNext [2];
  logic [AWIDTH-1:0] bankCount     [2];
  logic [AWIDTH-1:0] bankCountNext [2];
  logic              wptr, wptrNext, rptr, rptrNext;
  logic              errNext, wrGrant, rdGrant;
  logic              anyFilling, anyDraining, countBad;
  logic [1:0]        fullNext;

  assign anyFilling  = (bankState[0] == FILLING)  || (bankState[1] == FILLING);
  assign anyDraining = (bankState[0] == DRAINING) || (bankState[1] == DRAINING);
  assign countBad    = (wr_count == '0) || (wr_count > DepthW);

  // Grants look only at registered state, so a done never turns into an ack in the same cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bankStateNext[i] = bankState[i];
      bankCountNext[i] = bankCount[i];
    end
    wptrNext = wptr;
    rptrNext = rptr;
    errNext  = proto_err;
    wrGrant  = wr_req && (bankState[wptr] == EMPTY) && !anyFilling;
    rdGrant  = rd_req && (bankState[rptr] == FULL) && !anyDraining;

    if (wrGrant) bankStateNext[wptr] = FILLING;
    if (rdGrant) bankStateNext[rptr] = DRAINING;

    // Only one bank can be FILLING, and it is always the last one granted.
    if (wr_done) begin
      if (anyFilling) begin
        bankStateNext[wr_bank] = FULL;
        bankCountNext[wr_bank] = countBad ? DepthW : wr_count;
        wptrNext = ~wptr;
        if (countBad) errNext = 1'b1;
      end else begin
        errNext = 1'b1;
      end
    end

    if (rd_done) begin
      if (anyDraining) begin
        bankStateNext[rd_bank] = EMPTY;
        rptrNext = ~rptr;
      end else begin
        errNext = 1'b1;
      end
    end

    for (int i = 0; i < 2; i++) begin
      fullNext[i] = (bankStateNext[i] == FULL) || (bankStateNext[i] == DRAINING);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < 2; i++) begin
        bankState[i] <= EMPTY;
        bankCount[i] <= '0;
      end
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      wr_ack    <= 1'b0;
      wr_bank   <= 1'b0;
      rd_ack    <= 1'b0;
      rd_bank   <= 1'b0;
      rd_count  <= '0;
      bank_full <= 2'b00;
      proto_err <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bankState[i] <= bankStateNext[i];
        bankCount[i] <= bankCountNext[i];
      end
      wptr      <= wptrNext;
      rptr      <= rptrNext;
      wr_ack    <= wrGrant;
      rd_ack    <= rdGrant;
      bank_full <= fullNext;
      proto_err <= errNext;
      if (wrGrant) wr_bank <= wptr;
      if (rdGrant) begin
        rd_bank  <= rptr;
        rd_count <= bankCount[rptr];
      end
    end
  end

endmodule

// File: tb/tb_actbuf_pingpong_ctrl.sv
// tb/tb_actbuf_pingpong_ctrl.sv - self-checking bench for actbuf_pingpong_ctrl
module tb_actbuf_pingpong_ctrl;

  logic       ap_clk, ap_rst;
  logic       wr_req, wr_ack, wr_bank, wr_done;
  logic [8:0] wr_count;
  logic       rd_req, rd_ack, rd_bank, rd_done;
  logic [8:0] rd_count;
  logic [1:0] bank_full;
  logic       proto_err;

  int checks = 0;
  int errors = 0;

  actbuf_pingpong_ctrl #(.AWIDTH(9), .DEPTH(264)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_bank(wr_bank),
    .wr_done(wr_done), .wr_count(wr_count),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_bank(rd_bank), .rd_count(rd_count),
    .rd_done(rd_done), .bank_full(bank_full), .proto_err(proto_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic       rst, wrReq, wrDone;
    logic [8:0] wrCount;
    logic       rdReq, rdDone;
    logic       expWa, expWb, expRa, expRb;
    logic [8:0] expRc;
    logic [1:0] expBf;
    logic       expErr;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  logic bankQ[$];

  function automatic vec_t mk(logic rst, logic wrq, logic wd, int wc, logic rrq, logic rd,
                              logic wa, logic wb, logic ra, logic rb, int rc,
                              logic [1:0] bf, logic er);
    vec_t v;
    v.rst = rst; v.wrReq = wrq; v.wrDone = wd; v.wrCount = 9'(wc);
    v.rdReq = rrq; v.rdDone = rd;
    v.expWa = wa; v.expWb = wb; v.expRa = ra; v.expRb = rb; v.expRc = 9'(rc);
    v.expBf = bf; v.expErr = er;
    return v;
  endfunction

  task automatic check(string name, int row, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s row %0d actual %0d required %0d", name, row, act, req);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(logic rst, logic wrq, logic wd, int wc, logic rrq, logic rd);
    ap_rst = rst; wr_req = wrq; wr_done = wd; wr_count = 9'(wc);
    rd_req = rrq; rd_done = rd;
  endtask

  task automatic waitWrAck(int row);
    bit seen = 0;
    logic b;
    for (int c = 0; c < 4 && !seen; c++) begin
      tick();
      if (wr_ack) seen = 1;
    end
    check("wr_ack_timeout", row, int'(seen), 1);
    b = bankQ.pop_front();
    if (seen) check("seq_wr_bank", row, int'(wr_bank), int'(b));
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);

    //             rst wrq wd cnt rrq rd    wa wb ra rb  rc   bf   err
    vecs.push_back(mk(1, 0, 0,   0, 0, 0,   0, 0, 0, 0,   0, 2'b00, 0));
    vecs.push_back(mk(0, 1, 0,   0, 0, 0,   1, 0, 0, 0,   0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 1, 264, 1, 0,   0, 0, 0, 0,   0, 2'b01, 0));
    vecs.push_back(mk(0, 1, 0,   0, 1, 0,   1, 1, 1, 0, 264, 2'b01, 0));
    vecs.push_back(mk(0, 0, 1, 100, 0, 0,   0, 1, 0, 0, 264, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0,   0, 0, 0,   0, 1, 0, 0, 264, 2'b11, 0));
    vecs.push_back(mk(0, 1, 0,   0, 0, 1,   0, 1, 0, 0, 264, 2'b10, 0));
    vecs.push_back(mk(0, 1, 0,   0, 0, 0,   1, 0, 0, 0, 264, 2'b10, 0));
    vecs.push_back(mk(0, 0, 1,  50, 0, 0,   0, 0, 0, 0, 264, 2'b11, 0));
    vecs.push_back(mk(0, 0, 0,   0, 1, 0,   0, 0, 1, 1, 100, 2'b11, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1,   0, 0, 0, 1, 100, 2'b01, 0));
    vecs.push_back(mk(0, 0, 0,   0, 1, 0,   0, 0, 1, 0,  50, 2'b01, 0));
    vecs.push_back(mk(0, 1, 0,   0, 0, 0,   1, 1, 0, 0,  50, 2'b01, 0));
    vecs.push_back(mk(0, 0, 1, 200, 0, 1,   0, 1, 0, 0,  50, 2'b10, 0));
    vecs.push_back(mk(0, 0, 1,  10, 0, 0,   0, 1, 0, 0,  50, 2'b10, 1));
    vecs.push_back(mk(0, 1, 0,   0, 0, 0,   1, 0, 0, 0,  50, 2'b10, 1));
    vecs.push_back(mk(0, 0, 1, 300, 0, 0,   0, 0, 0, 0,  50, 2'b11, 1));
    vecs.push_back(mk(0, 0, 0,   0, 1, 0,   0, 0, 1, 1, 200, 2'b11, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1,   0, 0, 0, 1, 200, 2'b01, 1));
    vecs.push_back(mk(0, 0, 0,   0, 1, 0,   0, 0, 1, 0, 264, 2'b01, 1));
    vecs.push_back(mk(0, 1, 0,   0, 0, 0,   1, 1, 0, 0, 264, 2'b01, 1));
    vecs.push_back(mk(1, 0, 1,   7, 0, 1,   0, 0, 0, 0,   0, 2'b00, 0));
    vecs.push_back(mk(0, 1, 0,   0, 1, 0,   1, 0, 0, 0,   0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0,   0, 0, 1,   0, 0, 0, 0,   0, 2'b00, 1));
    vecs.push_back(mk(0, 0, 1,   0, 0, 0,   0, 0, 0, 0,   0, 2'b01, 1));
    vecs.push_back(mk(0, 0, 0,   0, 1, 0,   0, 0, 1, 0, 264, 2'b01, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t e;
      drive(vecs[i].rst, vecs[i].wrReq, vecs[i].wrDone, int'(vecs[i].wrCount),
            vecs[i].rdReq, vecs[i].rdDone);
      expQ.push_back(vecs[i]);
      tick();
      e = expQ.pop_front();
      check("wr_ack",    i, int'(wr_ack),    int'(e.expWa));
      check("wr_bank",   i, int'(wr_bank),   int'(e.expWb));
      check("rd_ack",    i, int'(rd_ack),    int'(e.expRa));
      check("rd_bank",   i, int'(rd_bank),   int'(e.expRb));
      check("rd_count",  i, int'(rd_count),  int'(e.expRc));
      check("bank_full", i, int'(bank_full), int'(e.expBf));
      check("proto_err", i, int'(proto_err), int'(e.expErr));
    end

    // A request left high after its ack must not win a second grant while the bank fills.
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    bankQ.push_back(1'b0);
    waitWrAck(100);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("held_req_no_ack", 101 + c, int'(wr_ack), 0);
    end
    drive(0, 0, 1, 5, 0, 0);
    tick();
    check("seq_bank_full", 104, int'(bank_full), 1);
    drive(0, 1, 0, 0, 0, 0);
    bankQ.push_back(1'b1);
    waitWrAck(105);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("seq_no_err", 106, int'(proto_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
